rr_mux4x1: RTL
==============

Name: rr_mux4x1

Overview:
Four-input, one-output stream multiplexer with round-robin arbitration and packet locking. It merges four valid/ready source channels onto one registered output channel. It also reports the source channel index, so that a downstream 1-to-4 demultiplexer can route responses back. It sits at the fan-in point of a 4-way channel group, and is the merging counterpart of the 4-way demultiplexer in the same datapath.

Parameters:
WIDTH, 8, data width of every input channel and of the output.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
d0, d1, d2, d3  input  WIDTH each  input channel data
v0, v1, v2, v3  input  1 each  input channel valid
l0, l1, l2, l3  input  1 each  input channel last-beat-of-packet flag
r0, r1, r2, r3  output  1 each  input channel ready
y  output  WIDTH  output data (registered)
yv  output  1  output valid (registered)
yl  output  1  output last flag (registered)
ys  output  2  source channel index of the current output beat (registered)
yr  input  1  output ready from downstream

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
  - While rst=1 at a clock edge, the next state is y=0, yv=0, yl=0, ys=0, the lock is cleared (state IDLE), and the round-robin pointer ptr=0.
  - r0..r3 are forced to 0 while rst=1.
  - Reset asserted mid-packet drops the lock and any held output beat. No recovery of the partial packet.
- Output slot: out_free = !yv | yr.
- Input transfer on channel i: vi & ri at the clock edge.
- Output transfer: yv & yr at the clock edge.
- State machine, two states: IDLE and LOCKED(ch), where ch is 2 bits.
- IDLE:
  - Grant g is the first i with vi=1, searching in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - rg = out_free; all other r = 0. If no vi is set, all r = 0.
  - On a transfer: y<=dg, yl<=lg, ys<=g, yv<=1.
    - If lg=1: stay IDLE and set ptr<=g+1 (mod 4).
    - If lg=0: go to LOCKED(g).
- LOCKED(ch):
  - Only channel ch is served: rch = out_free; all other r = 0, whatever their valids.
  - On a transfer: load y/yl/ys/yv as in IDLE.
    - If lch=1: go to IDLE and set ptr<=ch+1.
    - Otherwise stay LOCKED.
- No transfer but output transfer: yv<=0. y, yl and ys hold their last values.
- Simultaneous input and output transfer in the same cycle: the new beat is loaded and yv stays 1. Full throughput is 1 beat per clock.
- Output stalled (yv=1, yr=0): y, yl, ys and yv are held stable. All r = 0. State and ptr are unchanged.
- Latency: an input beat accepted at edge N appears on y/yv after edge N and is visible during cycle N+1.
- r0..r3 depend combinationally on yr, v0..v3, the state and ptr. They must never depend on d or l.
- Validity rule: at most one ri is 1 in any cycle. The bench checks this as an assertion.
- Fairness: a channel holding vi=1 is granted within at most 3 other packets.
- Single-beat packets (li=1 on the first beat) never enter LOCKED.
- Source protocol assumptions on sources:
  - vi, di and li stay stable until accepted.
  - A source may drop vi mid-packet. The lock is then held and other channels wait; this is not an error.

Test Plan:
- Reset check: rst=1 for 2 cycles with v0..v3=1 -> r0..r3=0 throughout. After release: yv=0, ys=0, ptr=0.
- Round-robin fairness: v0..v3=1 always, all li=1, d0..d3=8'h10/8'h20/8'h30/8'h40, yr=1.
  - ys sequence is 0,1,2,3,0,1 and y is 10,20,30,40,10,20.
  - One beat per clock, with yv continuously 1 after the first beat.
- Packet lock: ch2 sends 3 beats (AA, BB, CC; l2=1 on CC) while v0=1 and v3=1.
  - y is AA, BB, CC with ys=2, contiguous; r0=r3=0 meanwhile.
  - The next grant is ch3 (ptr=3).
- Backpressure: yr=0 for 4 cycles while a beat is held.
  - y, ys and yl are stable; yv=1; all r=0.
  - After yr=1, the next beat follows the held one with no loss and no duplication.
- Reset mid-packet: ch1 locked after 2 beats with l1=0, then rst=1 for 1 cycle, then v0=1 and v1=1.
  - yv=0 after reset.
  - The first grant is ch0 (ptr=0, lock cleared).
- Sparse traffic: only v3 pulses one beat with l3=1, then idle.
  - ys=3 and yv=1 for exactly 1 cycle with yr=1.
  - Next, a v0 beat is granted to ch0 (ptr wrapped to 0).

Source files
------------

// File: rtl/rr_mux4x1.sv
// Four-to-one valid/ready stream mux with round-robin arbitration and packet locking.
// Output beat, last flag and source index are registered; readies are combinational.
module rr_mux4x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    input  logic             l0,
    input  logic             l1,
    input  logic             l2,
    input  logic             l3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] y,
    output logic             yv,
    output logic             yl,
    output logic [1:0]       ys,
    input  logic             yr
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [WIDTH-1:0] d_arr [4];
    logic [3:0]       v_vec;
    logic [3:0]       l_vec;
    logic [3:0]       r_vec;

    logic [0:0]       state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             yv_q, yv_d;
    logic             yl_q, yl_d;
    logic [1:0]       ys_q, ys_d;

    logic             out_free;
    logic             any_v;
    logic [1:0]       grant;
    logic [1:0]       sel;
    logic [1:0]       idx;
    logic             in_xfer;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;
    assign v_vec    = {v3, v2, v1, v0};
    assign l_vec    = {l3, l2, l1, l0};
    assign {r3, r2, r1, r0} = r_vec;

    assign out_free = ~yv_q | yr;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        any_v = 1'b0;
        grant = ptr_q;
        idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (v_vec[idx]) begin
                any_v = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        sel   = (state_q == StLocked) ? ch_q : grant;
        r_vec = '0;
        if (!rst && ((state_q == StLocked) || any_v)) begin
            r_vec[sel] = out_free;
        end
        in_xfer = v_vec[sel] & r_vec[sel];
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        yv_d    = yv_q;
        yl_d    = yl_q;
        ys_d    = ys_q;
        if (in_xfer) begin
            y_d  = d_arr[sel];
            yl_d = l_vec[sel];
            ys_d = sel;
            yv_d = 1'b1;
            if (l_vec[sel]) begin
                state_d = StIdle;
                ptr_d   = sel + 2'd1;
            end else begin
                state_d = StLocked;
                ch_d    = sel;
            end
        end else if (yv_q && yr) begin
            yv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ch_q    <= '0;
            ptr_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            yl_q    <= 1'b0;
            ys_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            yl_q    <= yl_d;
            ys_q    <= ys_d;
        end
    end

    assign y  = y_q;
    assign yv = yv_q;
    assign yl = yl_q;
    assign ys = ys_q;

endmodule
